// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the trap controller: CSR addresses, cause codes,
// stall encodings and the FSM state type.
package trap_ctrl_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ILLEGAL   = 32'h0000_0002;
  localparam logic [31:0] CAUSE_EBREAK    = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL     = 32'h0000_000B;
  localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;

  localparam logic [5:0] STALL_ALL  = 6'b111111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MEPC,
    ST_WR_MCAUSE,
    ST_WR_MSTATUS,
    ST_MRET_WR,
    ST_FLUSH
  } trap_state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_TRAP,
    REQ_MRET
  } req_kind_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of EX-stage request flags, CSR snapshots and the trap controller's
// stall / redirect / CSR-write outputs.
interface trap_ctrl_if
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
  logic                  inst_valid_i;
  logic [ADDR_WIDTH-1:0] inst_addr_i;
  logic                  illegal_i;
  logic                  ecall_i;
  logic                  ebreak_i;
  logic                  mret_i;
  logic                  irq_ext_i;
  logic                  irq_timer_i;
  logic                  jump_flush_i;
  logic [ADDR_WIDTH-1:0] csr_mstatus_i;
  logic [ADDR_WIDTH-1:0] csr_mie_i;
  logic [ADDR_WIDTH-1:0] csr_mtvec_i;
  logic [ADDR_WIDTH-1:0] csr_mepc_i;

  logic [5:0]            stall_o;
  logic                  flush_int_o;
  logic [ADDR_WIDTH-1:0] int_pc_o;
  logic                  csr_we_o;
  logic [11:0]           csr_waddr_o;
  logic [ADDR_WIDTH-1:0] csr_wdata_o;

  modport master (
    output inst_valid_i, inst_addr_i, illegal_i, ecall_i, ebreak_i, mret_i,
           irq_ext_i, irq_timer_i, jump_flush_i,
           csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
    input  stall_o, flush_int_o, int_pc_o, csr_we_o, csr_waddr_o, csr_wdata_o
  );

  modport slave (
    input  inst_valid_i, inst_addr_i, illegal_i, ecall_i, ebreak_i, mret_i,
           irq_ext_i, irq_timer_i, jump_flush_i,
           csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
    output stall_o, flush_int_o, int_pc_o, csr_we_o, csr_waddr_o, csr_wdata_o
  );

endinterface

// File: rtl/trap_prio.sv
// Combinational request arbiter: picks the highest-priority trap/mret request
// in the EX stage and the matching mcause value.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic        inst_valid_i,
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        jump_flush_i,
  input  logic        mstatus_mie_i,
  input  logic        mie_meie_i,
  input  logic        mie_mtie_i,
  output req_kind_e   req_o,
  output logic [31:0] cause_o
);

  logic irq_window;
  logic ext_take;
  logic timer_take;

  // Interrupts wait out a redirect so mepc never points at a squashed slot.
  assign irq_window = inst_valid_i & ~jump_flush_i & mstatus_mie_i;
  assign ext_take   = irq_window & irq_ext_i & mie_meie_i;
  assign timer_take = irq_window & irq_timer_i & mie_mtie_i;

  always_comb begin
    req_o   = REQ_NONE;
    cause_o = '0;
    if (inst_valid_i && illegal_i) begin
      req_o   = REQ_TRAP;
      cause_o = CAUSE_ILLEGAL;
    end else if (inst_valid_i && ecall_i) begin
      req_o   = REQ_TRAP;
      cause_o = CAUSE_ECALL;
    end else if (inst_valid_i && ebreak_i) begin
      req_o   = REQ_TRAP;
      cause_o = CAUSE_EBREAK;
    end else if (inst_valid_i && mret_i) begin
      req_o   = REQ_MRET;
    end else if (ext_take) begin
      req_o   = REQ_TRAP;
      cause_o = CAUSE_IRQ_EXT;
    end else if (timer_take) begin
      req_o   = REQ_TRAP;
      cause_o = CAUSE_IRQ_TIMER;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/mstatus on a trap (or mstatus on
// mret) while stalling the pipe, then issues a single-cycle redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic       clk_i,
  input  logic       rst_i,
  trap_ctrl_if.slave bus
);

  typedef logic [ADDR_WIDTH-1:0] word_t;

  function automatic word_t mstatus_on_trap(input word_t ms);
    word_t r;
    r               = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic word_t mstatus_on_mret(input word_t ms);
    word_t r;
    r               = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  req_kind_e   prio_req;
  logic [31:0] prio_cause;

  trap_prio u_prio (
    .inst_valid_i  (bus.inst_valid_i),
    .illegal_i     (bus.illegal_i),
    .ecall_i       (bus.ecall_i),
    .ebreak_i      (bus.ebreak_i),
    .mret_i        (bus.mret_i),
    .irq_ext_i     (bus.irq_ext_i),
    .irq_timer_i   (bus.irq_timer_i),
    .jump_flush_i  (bus.jump_flush_i),
    .mstatus_mie_i (bus.csr_mstatus_i[MSTATUS_MIE]),
    .mie_meie_i    (bus.csr_mie_i[MIE_MEIE]),
    .mie_mtie_i    (bus.csr_mie_i[MIE_MTIE]),
    .req_o         (prio_req),
    .cause_o       (prio_cause)
  );

  trap_state_e state_q, state_d;
  word_t       pc_q, pc_d;
  word_t       cause_q, cause_d;
  word_t       target_q, target_d;

  logic [5:0]  stall_q, stall_d;
  logic        flush_q, flush_d;
  word_t       int_pc_q, int_pc_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  word_t       wdata_q, wdata_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    target_d = target_q;

    unique case (state_q)
      ST_IDLE: begin
        if (prio_req == REQ_TRAP) begin
          state_d = ST_WR_MEPC;
          pc_d    = bus.inst_addr_i;
          cause_d = word_t'(prio_cause);
        end else if (prio_req == REQ_MRET) begin
          state_d  = ST_MRET_WR;
          target_d = bus.csr_mepc_i;
        end
      end
      ST_WR_MEPC:    state_d = ST_WR_MCAUSE;
      ST_WR_MCAUSE:  state_d = ST_WR_MSTATUS;
      ST_WR_MSTATUS: state_d = ST_FLUSH;
      ST_MRET_WR:    state_d = ST_FLUSH;
      ST_FLUSH:      state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    stall_d  = STALL_NONE;
    flush_d  = 1'b0;
    int_pc_d = '0;
    we_d     = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;

    unique case (state_d)
      ST_WR_MEPC: begin
        stall_d = STALL_ALL;
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        wdata_d = pc_d;
      end
      ST_WR_MCAUSE: begin
        stall_d = STALL_ALL;
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        wdata_d = cause_d;
      end
      ST_WR_MSTATUS: begin
        stall_d = STALL_ALL;
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = mstatus_on_trap(bus.csr_mstatus_i);
      end
      ST_MRET_WR: begin
        stall_d = STALL_ALL;
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = mstatus_on_mret(bus.csr_mstatus_i);
      end
      ST_FLUSH: begin
        flush_d  = 1'b1;
        int_pc_d = (state_q == ST_MRET_WR) ? target_q
                                           : {bus.csr_mtvec_i[ADDR_WIDTH-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
      stall_q  <= STALL_NONE;
      flush_q  <= 1'b0;
      int_pc_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      int_pc_q <= int_pc_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.stall_o     = stall_q;
  assign bus.flush_int_o = flush_q;
  assign bus.int_pc_o    = int_pc_q;
  assign bus.csr_we_o    = we_q;
  assign bus.csr_waddr_o = waddr_q;
  assign bus.csr_wdata_o = wdata_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a vector table of single requests plus hand-written
// sequences for held requests, irq retake after mret and mid-sequence reset.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  trap_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
  trap_ctrl #(.ADDR_WIDTH(AW)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  // flags = {illegal, ecall, ebreak, mret, irq_ext, irq_timer, jump_flush, inst_valid}
  // kind: 0 = no acceptance, 1 = trap, 2 = mret
  typedef struct {
    logic [7:0]  flags;
    logic [31:0] addr, ms, mie, mtvec, mepc;
    int          kind;
    logic [31:0] e_cause, e_ms, e_ipc;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [7:0] f, input logic [31:0] a, ms, mie, mtvec, mepc,
                              input int kind, input logic [31:0] c, ems, ipc);
    vec_t v;
    v.flags = f; v.addr = a; v.ms = ms; v.mie = mie; v.mtvec = mtvec; v.mepc = mepc;
    v.kind = kind; v.e_cause = c; v.e_ms = ems; v.e_ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {bus.illegal_i, bus.ecall_i, bus.ebreak_i, bus.mret_i,
     bus.irq_ext_i, bus.irq_timer_i, bus.jump_flush_i, bus.inst_valid_i} = v.flags;
    bus.inst_addr_i   = v.addr;
    bus.csr_mstatus_i = v.ms;
    bus.csr_mie_i     = v.mie;
    bus.csr_mtvec_i   = v.mtvec;
    bus.csr_mepc_i    = v.mepc;
  endtask

  task automatic clr(input bit sync_flags, input bit irq_flags);
    if (sync_flags) {bus.illegal_i, bus.ecall_i, bus.ebreak_i, bus.mret_i} = 4'b0000;
    if (irq_flags)  {bus.irq_ext_i, bus.irq_timer_i} = 2'b00;
  endtask

  task automatic chk_cycle(input string tag, input logic e_we, input logic [11:0] e_addr,
                           input logic [31:0] e_data, input logic [5:0] e_stall,
                           input logic e_flush, input logic [31:0] e_ipc);
    chk({tag, " we"},    32'(bus.csr_we_o),    32'(e_we));
    chk({tag, " stall"}, 32'(bus.stall_o),     32'(e_stall));
    chk({tag, " flush"}, 32'(bus.flush_int_o), 32'(e_flush));
    if (e_we) begin
      chk({tag, " waddr"}, 32'(bus.csr_waddr_o), 32'(e_addr));
      chk({tag, " wdata"}, bus.csr_wdata_o, e_data);
    end
    if (e_flush) chk({tag, " int_pc"}, bus.int_pc_o, e_ipc);
  endtask

  // Called at the negedge where the request was just driven; returns at the
  // negedge of the FLUSH cycle (or of the unchanged IDLE cycle for kind 0).
  task automatic check_seq(input string tag, input int kind, input logic [31:0] pc, cause,
                           ems, ipc, input bit clr_sync, input bit clr_irq);
    @(negedge clk);
    clr(clr_sync, clr_irq);
    case (kind)
      1: begin
        chk_cycle({tag, " c1"}, 1'b1, CSR_MEPC, pc, STALL_ALL, 1'b0, 32'h0);
        @(negedge clk);
        chk_cycle({tag, " c2"}, 1'b1, CSR_MCAUSE, cause, STALL_ALL, 1'b0, 32'h0);
        @(negedge clk);
        chk_cycle({tag, " c3"}, 1'b1, CSR_MSTATUS, ems, STALL_ALL, 1'b0, 32'h0);
        @(negedge clk);
        chk_cycle({tag, " c4"}, 1'b0, 12'h0, 32'h0, STALL_NONE, 1'b1, ipc);
      end
      2: begin
        chk_cycle({tag, " c1"}, 1'b1, CSR_MSTATUS, ems, STALL_ALL, 1'b0, 32'h0);
        @(negedge clk);
        chk_cycle({tag, " c2"}, 1'b0, 12'h0, 32'h0, STALL_NONE, 1'b1, ipc);
      end
      default: chk_cycle({tag, " idle"}, 1'b0, 12'h0, 32'h0, STALL_NONE, 1'b0, 32'h0);
    endcase
    $display("[TB] %s kind=%0d pc=%h cause=%h mstatus=%h target=%h", tag, kind, pc, cause, ems, ipc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " we"},     32'(bus.csr_we_o),    32'h0);
    chk({tag, " waddr"},  32'(bus.csr_waddr_o), 32'h0);
    chk({tag, " wdata"},  bus.csr_wdata_o,      32'h0);
    chk({tag, " stall"},  32'(bus.stall_o),     32'h0);
    chk({tag, " flush"},  32'(bus.flush_int_o), 32'h0);
    chk({tag, " int_pc"}, bus.int_pc_o,         32'h0);
  endtask

  initial begin
    vecs[0]  = mk(8'b1000_0001, 32'h100,  32'h8,        32'h0,   32'h80,       32'h0,    1, 32'h2,        32'h80,       32'h80);
    vecs[1]  = mk(8'b0000_0101, 32'h24,   32'h8,        32'h80,  32'h200,      32'h0,    1, 32'h80000007, 32'h80,       32'h200);
    vecs[2]  = mk(8'b0000_1101, 32'h40,   32'h1808,     32'h880, 32'h200,      32'h0,    1, 32'h8000000B, 32'h1880,     32'h200);
    vecs[3]  = mk(8'b0000_1111, 32'h40,   32'h1808,     32'h880, 32'h200,      32'h0,    0, 32'h0,        32'h0,        32'h0);
    vecs[4]  = mk(8'b0001_0001, 32'h0,    32'h80,       32'h0,   32'h200,      32'h104,  2, 32'h0,        32'h88,       32'h104);
    vecs[5]  = mk(8'b0100_1001, 32'h300,  32'h8,        32'h800, 32'h103,      32'h0,    1, 32'hB,        32'h80,       32'h100);
    vecs[6]  = mk(8'b0010_0001, 32'h50,   32'h0,        32'h0,   32'h80,       32'h0,    1, 32'h3,        32'h0,        32'h80);
    vecs[7]  = mk(8'b1000_0011, 32'h60,   32'h8,        32'h0,   32'h80,       32'h0,    1, 32'h2,        32'h80,       32'h80);
    vecs[8]  = mk(8'b0000_1001, 32'h64,   32'h0,        32'h800, 32'h80,       32'h0,    0, 32'h0,        32'h0,        32'h0);
    vecs[9]  = mk(8'b0000_0100, 32'h68,   32'h8,        32'h80,  32'h80,       32'h0,    0, 32'h0,        32'h0,        32'h0);
    vecs[10] = mk(8'b1000_0000, 32'h6C,   32'h8,        32'h0,   32'h80,       32'h0,    0, 32'h0,        32'h0,        32'h0);
    vecs[11] = mk(8'b1111_0001, 32'h70,   32'h8,        32'h0,   32'h80,       32'h0,    1, 32'h2,        32'h80,       32'h80);
    vecs[12] = mk(8'b0001_0001, 32'h0,    32'h8,        32'h0,   32'h80,       32'h2000, 2, 32'h0,        32'h80,       32'h2000);
    vecs[13] = mk(8'b0000_1101, 32'h88,   32'h8,        32'h80,  32'h80,       32'h0,    1, 32'h80000007, 32'h80,       32'h80);
    vecs[14] = mk(8'b0001_1001, 32'h0,    32'hFFFFFF7F, 32'h800, 32'h80,       32'h104,  2, 32'h0,        32'hFFFFFFF7, 32'h104);
    vecs[15] = mk(8'b1000_0001, 32'h1234, 32'hA5A5A5AD, 32'h0,   32'hFFFF0001, 32'h0,    1, 32'h2,        32'hA5A5A5A5, 32'hFFFF0000);

    rst_n = 1'b0;
    drive(mk(8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0));
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      check_seq($sformatf("vec%0d", i), vecs[i].kind, vecs[i].addr, vecs[i].e_cause,
                vecs[i].e_ms, vecs[i].e_ipc, 1'b1, 1'b1);
    end

    // Request held through FLUSH: ignored there, retaken from the next IDLE cycle.
    @(negedge clk);
    drive(mk(8'b1000_0001, 32'h400, 32'h8, 32'h0, 32'h80, 32'h0, 0, 32'h0, 32'h0, 32'h0));
    check_seq("held_a", 1, 32'h400, 32'h2, 32'h80, 32'h80, 1'b0, 1'b0);
    @(negedge clk);
    chk_cycle("held_idle", 1'b0, 12'h0, 32'h0, STALL_NONE, 1'b0, 32'h0);
    check_seq("held_b", 1, 32'h400, 32'h2, 32'h80, 32'h80, 1'b1, 1'b1);

    // ecall beats a pending irq; irq is retaken once mret restores MIE.
    @(negedge clk);
    drive(mk(8'b0100_1001, 32'h300, 32'h8, 32'h800, 32'h80, 32'h0, 0, 32'h0, 32'h0, 32'h0));
    check_seq("ecall_irq", 1, 32'h300, 32'hB, 32'h80, 32'h80, 1'b1, 1'b0);
    bus.csr_mstatus_i = 32'h80;
    @(negedge clk);
    chk_cycle("irq_masked", 1'b0, 12'h0, 32'h0, STALL_NONE, 1'b0, 32'h0);
    bus.mret_i     = 1'b1;
    bus.csr_mepc_i = 32'h300;
    check_seq("mret_back", 2, 32'h0, 32'h0, 32'h88, 32'h300, 1'b1, 1'b0);
    bus.csr_mstatus_i = 32'h88;
    @(negedge clk);
    chk_cycle("pre_retake", 1'b0, 12'h0, 32'h0, STALL_NONE, 1'b0, 32'h0);
    check_seq("irq_retaken", 1, 32'h300, 32'h8000000B, 32'h80, 32'h80, 1'b1, 1'b1);

    // Reset during WR_MCAUSE aborts without any further CSR write.
    @(negedge clk);
    drive(mk(8'b1000_0001, 32'h500, 32'h8, 32'h0, 32'h80, 32'h0, 0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    clr(1'b1, 1'b1);
    chk_cycle("rst_c1", 1'b1, CSR_MEPC, 32'h500, STALL_ALL, 1'b0, 32'h0);
    @(negedge clk);
    chk_cycle("rst_c2", 1'b1, CSR_MCAUSE, 32'h2, STALL_ALL, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    @(negedge clk);
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_cycle("rst_after", 1'b0, 12'h0, 32'h0, STALL_NONE, 1'b0, 32'h0);
    end
    $display("[TB] reset mid-sequence checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
